// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Requester identities
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Latency counter width (supports MEM_LATENCY up to 7)
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundles both requester ports, the RAM side and status of the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_ready;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_ready;
  logic [DW-1:0] p1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          grant_id;

  // Arbiter side
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ready, p0_rdata, p1_ready, p1_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    output busy, grant_id
  );

  // Requesters and RAM side
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ready, p0_rdata, p1_ready, p1_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    input  busy, grant_id
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-input picker: round-robin on ties, or port 0 wins ties when fixed is set.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       gnt,
  output logic       valid
);

  // Select the winner among the active requests
  always_comb begin
    gnt   = PORT_CPU;
    valid = |req;
    case (req)
      2'b01:   gnt = PORT_CPU;
      2'b10:   gnt = PORT_DBG;
      2'b11:   gnt = fixed ? PORT_CPU : ~last;
      default: gnt = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the CPU load/store path and a debug/DMA master.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned FIXED_PRIO  = 0
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             we_q;

  logic             pick_gnt;
  logic             pick_valid;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  rr_pick2 u_pick (
    .req   ({bus.p1_req, bus.p0_req}),
    .last  (last_grant),
    .fixed (FIXED_PRIO != 0),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Operands of the port that wins this IDLE cycle
  always_comb begin
    sel_we    = bus.p0_we;
    sel_addr  = bus.p0_addr;
    sel_wdata = bus.p0_wdata;
    if (pick_gnt == PORT_DBG) begin
      sel_we    = bus.p1_we;
      sel_addr  = bus.p1_addr;
      sel_wdata = bus.p1_wdata;
    end
  end

  // Access sequencer: grant, hold RAM operands for the latency window, respond
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= PORT_DBG;
      we_q          <= 1'b0;
      bus.grant_id  <= PORT_CPU;
      bus.busy      <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.p0_ready  <= 1'b0;
      bus.p1_ready  <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
    end else begin
      bus.p0_ready <= 1'b0;
      bus.p1_ready <= 1'b0;
      bus.mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state         <= ACCESS;
            cnt           <= CNT_INIT;
            last_grant    <= pick_gnt;
            bus.grant_id  <= pick_gnt;
            bus.busy      <= 1'b1;
            we_q          <= sel_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.mem_we    <= sel_we;
            bus.mem_re    <= ~sel_we;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (bus.grant_id == PORT_DBG) bus.p1_rdata <= bus.mem_rdata;
              else                          bus.p0_rdata <= bus.mem_rdata;
            end
            if (bus.grant_id == PORT_DBG) bus.p1_ready <= 1'b1;
            else                          bus.p0_ready <= 1'b1;
            bus.mem_re <= 1'b0;
            state      <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy   <= 1'b0;
          bus.mem_re <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vectors, corner sequences, randomized model check.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned L0 = 2;
  localparam int unsigned L1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_init = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) b0 ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LATENCY(L0), .FIXED_PRIO(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0));
  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LATENCY(L1), .FIXED_PRIO(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1));

  // RAM models: data only valid in the last cycle of the read latency window
  logic [31:0] ram0 [16];
  logic [31:0] ram1 [16];
  logic [2:0]  run0, run1;

  function automatic logic [31:0] init_val(int i);
    return (i == 1) ? 32'hDEAD_BEEF : (32'h3C00_0000 | 32'(i * 17));
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) begin
        ram0[i] <= init_val(i);
        ram1[i] <= init_val(i);
      end
      run0 <= 3'd0;
      run1 <= 3'd0;
    end else begin
      if (b0.mem_we) ram0[b0.mem_addr[5:2]] <= b0.mem_wdata;
      if (b1.mem_we) ram1[b1.mem_addr[5:2]] <= b1.mem_wdata;
      run0 <= b0.mem_re ? run0 + 3'd1 : 3'd0;
      run1 <= b1.mem_re ? run1 + 3'd1 : 3'd0;
    end
  end

  assign b0.mem_rdata = (b0.mem_re && run0 == 3'(L0 - 1)) ? ram0[b0.mem_addr[5:2]] : 32'hBAD0_0000;
  assign b1.mem_rdata = (b1.mem_re && run1 == 3'(L1 - 1)) ? ram1[b1.mem_addr[5:2]] : 32'hBAD0_0001;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic drive_port(input bit p, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    if (!p) begin
      b0.p0_req = req; b0.p0_we = we; b0.p0_addr = addr; b0.p0_wdata = wdata;
    end else begin
      b0.p1_req = req; b0.p1_we = we; b0.p1_addr = addr; b0.p1_wdata = wdata;
    end
  endtask

  task automatic idle_inputs();
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    b1.p0_req = 1'b0; b1.p0_we = 1'b0; b1.p0_addr = 32'd0; b1.p0_wdata = 32'd0;
    b1.p1_req = 1'b0; b1.p1_we = 1'b0; b1.p1_addr = 32'd0; b1.p1_wdata = 32'd0;
  endtask

  task automatic do_reset(input bit init_ram);
    idle_inputs();
    rst = 1'b0;
    ram_init = init_ram;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ram_init = 1'b0;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  // One isolated access on dut0, measured against its table record
  task automatic run_vec(input vec_t v, input int idx);
    int lat, nre, nwe, other, both;
    bit seen;
    logic [31:0] waddr, wd, rd;
    lat = -1; nre = 0; nwe = 0; other = 0; both = 0; seen = 1'b0;
    waddr = 32'd0; wd = 32'd0;
    @(posedge clk);
    #1 drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (b0.mem_re) nre++;
      if (b0.mem_we) begin nwe++; waddr = b0.mem_addr; wd = b0.mem_wdata; end
      if (b0.mem_re && b0.mem_we) both++;
      if (v.port ? b0.p0_ready : b0.p1_ready) other++;
      if (v.port ? b0.p1_ready : b0.p0_ready) begin seen = 1'b1; lat = n; end
    end
    rd = v.port ? b0.p1_rdata : b0.p0_rdata;
    @(posedge clk);
    #1 drive_port(v.port, 1'b0, 1'b0, 32'd0, 32'd0);
    chk($sformatf("vec%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("vec%0d_rdata", idx), 64'(rd), 64'(v.exp_rdata));
    chk($sformatf("vec%0d_strobes", idx), {32'(nre), 32'(nwe)},
        {(v.we ? 32'd0 : 32'(L0)), (v.we ? 32'd1 : 32'd0)});
    chk($sformatf("vec%0d_excl", idx), {32'(other), 32'(both)}, 64'd0);
    if (v.we) chk($sformatf("vec%0d_waddr_data", idx), {waddr, wd}, {v.addr, v.wdata});
    @(negedge clk);
    chk($sformatf("vec%0d_idle_after", idx), 64'(b0.busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt0, cnt1, ng, bad;
    logic [3:0] ord;

    vecs[0] = '{1'b0, 1'b0, 32'h1001_0004, 32'h0,          32'hDEAD_BEEF, 3};
    vecs[1] = '{1'b1, 1'b1, 32'h1001_0008, 32'h0000_A5A5,  32'h0,         3};
    vecs[2] = '{1'b0, 1'b0, 32'h1001_0008, 32'h0,          32'h0000_A5A5, 3};
    vecs[3] = '{1'b1, 1'b0, 32'h1001_0004, 32'h0,          32'hDEAD_BEEF, 3};
    vecs[4] = '{1'b0, 1'b1, 32'h1001_000C, 32'h1234_5678,  32'h0000_A5A5, 3};
    vecs[5] = '{1'b1, 1'b0, 32'h1001_000C, 32'h0,          32'h1234_5678, 3};
    vecs[6] = '{1'b1, 1'b1, 32'h1001_0004, 32'hCAFE_F00D,  32'h1234_5678, 3};
    vecs[7] = '{1'b0, 1'b0, 32'h1001_0004, 32'h0,          32'hCAFE_F00D, 3};

    // Reset state
    idle_inputs();
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl0", {58'd0, b0.p0_ready, b0.p1_ready, b0.mem_we, b0.mem_re, b0.busy, b0.grant_id}, 64'd0);
    chk("rst_rdata0", {b0.p0_rdata, b0.p1_rdata}, 64'd0);
    chk("rst_mem0", {b0.mem_addr, b0.mem_wdata}, 64'd0);
    chk("rst_ctrl1", {58'd0, b1.p0_ready, b1.p1_ready, b1.mem_we, b1.mem_re, b1.busy, b1.grant_id}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    ram_init = 1'b0;

    // Directed single accesses
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset during ACCESS aborts the read
    @(posedge clk);
    #1 drive_port(1'b0, 1'b1, 1'b0, 32'h1001_0004, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_pre", {62'd0, b0.busy, b0.mem_re}, 64'd3);
    #1 rst = 1'b0;
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 chk("mid_abort", {61'd0, b0.mem_re, b0.busy, b0.p0_ready}, 64'd0);
    chk("mid_rdata_clr", 64'(b0.p0_rdata), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    cnt0 = 0;
    repeat (6) begin @(negedge clk); if (b0.p0_ready) cnt0++; end
    chk("mid_no_ready", {32'(cnt0), 31'd0, b0.busy}, 64'd0);

    // Round-robin tie: both ports held
    @(posedge clk);
    #1 drive_port(1'b0, 1'b1, 1'b0, 32'h1001_0004, 32'd0);
    drive_port(1'b1, 1'b1, 1'b0, 32'h1001_0008, 32'd0);
    ng = 0; bad = 0; ord = 4'd0;
    for (int n = 0; n < 4 * (L0 + 2); n++) begin
      @(negedge clk);
      if ((b0.p0_ready && b0.p1_ready) || (b0.mem_we && b0.mem_re)) bad++;
      if (b0.p0_ready || b0.p1_ready) begin
        if (ng < 4) ord[ng] = b0.p1_ready;
        ng++;
      end
    end
    @(posedge clk);
    #1 idle_inputs();
    chk("rr_count", {32'(ng), 32'(bad)}, {32'd4, 32'd0});
    chk("rr_order", 64'(ord), 64'(4'b1010));
    chk("rr_rdata", {b0.p0_rdata, b0.p1_rdata}, {32'hCAFE_F00D, 32'h0000_A5A5});
    repeat (2) @(negedge clk);
    chk("rr_idle", 64'(b0.busy), 64'd0);

    // Early drop: one-cycle request still completes
    @(posedge clk);
    #1 drive_port(1'b1, 1'b1, 1'b0, 32'h1001_000C, 32'd0);
    cnt1 = 0;
    @(negedge clk);
    if (b0.p1_ready) cnt1++;
    @(posedge clk);
    #1 drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (10) begin @(negedge clk); if (b0.p1_ready) cnt1++; end
    chk("drop_ready_once", 64'(cnt1), 64'd1);
    chk("drop_idle", 64'(b0.busy), 64'd0);
    chk("drop_rdata", 64'(b0.p1_rdata), 64'h1234_5678);

    // Fixed priority on dut1: port 0 keeps winning ties
    @(posedge clk);
    #1 b1.p0_req = 1'b1; b1.p0_addr = 32'h1001_0004;
    b1.p1_req = 1'b1; b1.p1_addr = 32'h1001_0008;
    cnt0 = 0; cnt1 = 0;
    for (int n = 0; n < 3 * (L1 + 2); n++) begin
      @(negedge clk);
      if (b1.p0_ready) cnt0++;
      if (b1.p1_ready) cnt1++;
    end
    @(posedge clk);
    #1 idle_inputs();
    chk("fixed_grants", {32'(cnt0), 32'(cnt1)}, {32'd3, 32'd0});
    chk("fixed_rdata", 64'(b1.p0_rdata), 64'hDEAD_BEEF);

    // Randomized traffic against a transaction-level model
    do_reset(1'b1);
    begin
      bit          pend [2];
      logic        rq_we [2];
      logic [31:0] rq_addr [2];
      logic [31:0] rq_wd [2];
      logic [31:0] ref_mem [16];
      bit          act, mport, mwe, last, egid, in_txn, w;
      int          s, r;
      logic [31:0] maddr, mwd, erd0, erd1;
      logic [5:0]  ectl;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
      for (int p = 0; p < 2; p++) begin
        pend[p] = 1'b0; rq_we[p] = 1'b0; rq_addr[p] = 32'd0; rq_wd[p] = 32'd0;
      end
      act = 1'b0; last = 1'b1; egid = 1'b0; s = 0; r = -1;
      mport = 1'b0; mwe = 1'b0; maddr = 32'd0; mwd = 32'd0; erd0 = 32'd0; erd1 = 32'd0;
      for (int j = 0; j < 400; j++) begin
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
          if (pend[p] && $urandom_range(0, 19) == 0) pend[p] = 1'b0;
          else if (!pend[p] && $urandom_range(0, 2) == 0) begin
            pend[p]    = 1'b1;
            rq_we[p]   = 1'($urandom_range(0, 1));
            rq_addr[p] = 32'h1001_0000 | 32'($urandom_range(0, 15) * 4);
            rq_wd[p]   = $urandom;
          end
          drive_port(p[0], pend[p], rq_we[p], rq_addr[p], rq_wd[p]);
        end
        @(negedge clk);
        in_txn = act && j >= s && j <= r;
        if (act && j == r && !mwe) begin
          if (mport) erd1 = ref_mem[maddr[5:2]];
          else       erd0 = ref_mem[maddr[5:2]];
        end
        ectl = {in_txn, in_txn && !mwe && j < r, in_txn && mwe && j == s,
                in_txn && j == r && !mport, in_txn && j == r && mport, egid};
        chk($sformatf("rnd%0d_ctrl", j),
            {58'd0, b0.busy, b0.mem_re, b0.mem_we, b0.p0_ready, b0.p1_ready, b0.grant_id}, 64'(ectl));
        chk($sformatf("rnd%0d_rdata", j), {b0.p0_rdata, b0.p1_rdata}, {erd0, erd1});
        if (in_txn)
          chk($sformatf("rnd%0d_mem", j), {b0.mem_addr, (mwe ? b0.mem_wdata : 32'd0)},
              {maddr, (mwe ? mwd : 32'd0)});
        if (b0.p0_ready) pend[0] = 1'b0;
        if (b0.p1_ready) pend[1] = 1'b0;
        if ((!act || j > r) && (b0.p0_req || b0.p1_req)) begin
          if (b0.p0_req && b0.p1_req) w = ~last;
          else                        w = b0.p1_req;
          act = 1'b1; s = j + 1; r = j + 1 + int'(L0);
          mport = w; last = w; egid = w;
          mwe   = w ? b0.p1_we : b0.p0_we;
          maddr = w ? b0.p1_addr : b0.p0_addr;
          mwd   = w ? b0.p1_wdata : b0.p0_wdata;
          if (mwe) ref_mem[maddr[5:2]] = mwd;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
